// File: rtl/data_mem_mmio_if.sv
// CPU data-side bus: byte address, store data, write strobe and combinational load data.
interface data_mem_mmio_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output MemWrite,
        output ALUResult,
        output WriteData,
        input  ReadData
    );

    modport slave (
        input  MemWrite,
        input  ALUResult,
        input  WriteData,
        output ReadData
    );
endinterface

// File: rtl/data_mem_mmio.sv
// Data memory for the single-cycle CPU: word RAM plus an MMIO window holding an
// LFSR, a free-running cycle counter, an LED register and edge-latched buttons.
module data_mem_mmio #(
    parameter int          DEPTH = 64,
    parameter int          NBTN  = 4,
    parameter logic [31:0] SEED  = 32'hACE1ACE1
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_mmio_if.slave    bus,
    input  logic [NBTN-1:0]   btn_in,
    output logic [7:0]        led_out
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   ram_idx;

    logic [31:0]     lfsr;
    logic [31:0]     lfsr_next;
    logic [31:0]     cycles;
    logic [NBTN-1:0] sync0;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] prev;
    logic [NBTN-1:0] sticky;
    logic [NBTN-1:0] btn_clr;
    logic [31:0]     btn_word;

    logic in_ram;
    logic in_mmio;
    logic ram_we;
    logic wr_rng;
    logic wr_cyc;
    logic wr_led;
    logic wr_btn;

    assign ram_idx = bus.ALUResult[AW+1:2];

    always_comb begin
        in_ram  = bus.ALUResult < RAM_BYTES;
        in_mmio = bus.ALUResult[31:4] == 28'h0000100;

        // RAM write is masked during reset so a store on a reset edge is lost
        ram_we = bus.MemWrite && in_ram && !rst;
        wr_rng = bus.MemWrite && in_mmio && (bus.ALUResult[3:2] == 2'd0);
        wr_cyc = bus.MemWrite && in_mmio && (bus.ALUResult[3:2] == 2'd1);
        wr_led = bus.MemWrite && in_mmio && (bus.ALUResult[3:2] == 2'd2);
        wr_btn = bus.MemWrite && in_mmio && (bus.ALUResult[3:2] == 2'd3);

        btn_clr = wr_btn ? bus.WriteData[NBTN-1:0] : '0;

        lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    end

    always_comb begin
        btn_word                = '0;
        btn_word[NBTN-1:0]      = sticky;
        btn_word[NBTN+15:16]    = sync1;
    end

    always_comb begin
        bus.ReadData = '0;
        if (in_ram) begin
            bus.ReadData = mem[ram_idx];
        end else if (in_mmio) begin
            unique case (bus.ALUResult[3:2])
                2'd0: bus.ReadData = lfsr;
                2'd1: bus.ReadData = cycles;
                2'd2: bus.ReadData = {24'b0, led_out};
                2'd3: bus.ReadData = btn_word;
                default: bus.ReadData = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= bus.WriteData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr    <= SEED;
            cycles  <= '0;
            led_out <= '0;
            sync0   <= '0;
            sync1   <= '0;
            prev    <= '0;
            sticky  <= '0;
        end else begin
            // A zero load would lock the LFSR, so it is forced to 1
            if (wr_rng) begin
                lfsr <= (bus.WriteData == 32'h0) ? 32'h00000001 : bus.WriteData;
            end else begin
                lfsr <= lfsr_next;
            end

            cycles <= wr_cyc ? bus.WriteData : cycles + 32'd1;

            if (wr_led) begin
                led_out <= bus.WriteData[7:0];
            end

            sync0  <= btn_in;
            sync1  <= sync0;
            prev   <= sync1;
            // Set is ORed in after the clear so a coincident edge survives
            sticky <= (sticky & ~btn_clr) | (sync1 & ~prev);
        end
    end
endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM, LFSR, cycle counter, LED and button MMIO.
module tb_data_mem_mmio;
    logic       clk;
    logic       rst;
    logic [3:0] btn_in;
    logic [7:0] led_out;

    int unsigned n_total;
    int unsigned n_bad;

    data_mem_mmio_if bus ();

    data_mem_mmio #(
        .DEPTH (64),
        .NBTN  (4),
        .SEED  (32'hACE1ACE1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .btn_in  (btn_in),
        .led_out (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and park on the following falling edge
    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus.ALUResult = addr;
        #1;
        data = bus.ReadData;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.MemWrite  = 1'b1;
        bus.ALUResult = addr;
        bus.WriteData = data;
        @(posedge clk);
        #1;
        bus.MemWrite  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        int unsigned zeros;

        n_total       = 0;
        n_bad         = 0;
        rst           = 1'b1;
        btn_in        = '0;
        bus.MemWrite  = 1'b0;
        bus.ALUResult = '0;
        bus.WriteData = '0;

        step(2);
        check("rst_led", {24'b0, led_out}, 32'h0);
        rd(32'h1000, r); check("rst_rng", r, 32'hACE1ACE1);
        rd(32'h1004, r); check("rst_cyc", r, 32'h0);
        rd(32'h100C, r); check("rst_btn", r, 32'h0);

        rst = 1'b0;
        rd(32'h1000, r); check("rng_first", r, 32'hACE1ACE1);
        step(1);
        rd(32'h1000, r); check("rng_step1", r, 32'hD650D673);
        rd(32'h1004, r); check("cyc_1", r, 32'd1);
        step(4);
        rd(32'h1004, r); check("cyc_5", r, 32'd5);

        zeros = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            rd(32'h1000, r);
            if (r == 32'h0) zeros++;
        end
        check("rng_nonzero", zeros, 32'd0);

        wr(32'h1000, 32'h0);
        rd(32'h1000, r); check("rng_load0", r, 32'h00000001);
        step(1);
        rd(32'h1000, r); check("rng_after1", r, 32'h80200003);
        wr(32'h1000, 32'h00000002);
        rd(32'h1000, r); check("rng_load2", r, 32'h00000002);
        step(1);
        rd(32'h1000, r); check("rng_shift", r, 32'h00000001);

        wr(32'h1004, 32'hFFFFFFFE);
        rd(32'h1004, r); check("cyc_load", r, 32'hFFFFFFFE);
        step(1);
        rd(32'h1004, r); check("cyc_max", r, 32'hFFFFFFFF);
        step(1);
        rd(32'h1004, r); check("cyc_wrap", r, 32'h0);
        wr(32'h1004, 32'd100);
        step(3);
        rd(32'h1004, r); check("ldr_cyc", r, 32'd103);

        wr(32'd0, 32'h0BADF00D);
        wr(32'd12, 32'h12345678);
        rd(32'd12, r); check("ram_12", r, 32'h12345678);
        wr(32'd13, 32'hDEADBEEF);
        rd(32'd12, r); check("ram_alias", r, 32'hDEADBEEF);
        rd(32'd15, r); check("ram_alias15", r, 32'hDEADBEEF);
        wr(32'd252, 32'hCAFEF00D);
        rd(32'd252, r); check("ram_top", r, 32'hCAFEF00D);
        rd(32'd256, r); check("ram_past", r, 32'h0);
        wr(32'd256, 32'h11111111);
        wr(32'h2000, 32'h55555555);
        rd(32'h2000, r); check("unmap_rd", r, 32'h0);
        rd(32'd0, r);    check("unmap_nowr", r, 32'h0BADF00D);
        rd(32'd252, r);  check("ram_top_keep", r, 32'hCAFEF00D);
        check("unmap_led", {24'b0, led_out}, 32'h0);

        bus.MemWrite  = 1'b1;
        bus.ALUResult = 32'h1008;
        bus.WriteData = 32'hABCD12F0;
        @(posedge clk);
        #1;
        check("led_edge", {24'b0, led_out}, 32'h000000F0);
        bus.MemWrite = 1'b0;
        @(negedge clk);
        rd(32'h1008, r); check("led_rd", r, 32'h000000F0);

        btn_in = 4'b0100;
        step(2);
        rd(32'h100C, r); check("btn_sync_only", r, 32'h00040000);
        step(1);
        rd(32'h100C, r); check("btn_sticky", r, 32'h00040004);
        rd(32'h100F, r); check("btn_alias", r, 32'h00040004);
        wr(32'h100C, 32'hFFFF0004);
        rd(32'h100C, r); check("btn_clear", r, 32'h00040000);

        btn_in = 4'b0000;
        step(4);
        rd(32'h100C, r); check("btn_low", r, 32'h0);
        btn_in = 4'b0100;
        step(2);
        wr(32'h100C, 32'h00000004);
        rd(32'h100C, r); check("btn_set_wins", r, 32'h00040004);

        rst = 1'b1;
        #1;
        check("rst_async_led", {24'b0, led_out}, 32'h0);
        rd(32'h1004, r); check("rst_async_cyc", r, 32'h0);
        rd(32'h1000, r); check("rst_async_rng", r, 32'hACE1ACE1);
        rd(32'h100C, r); check("rst_async_btn", r, 32'h0);
        rd(32'd252, r);  check("rst_ram_keep", r, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
